merge_pipe_row: RTL and testbench

Pipelined, parametrised successor to the combinational row mergers in the sorter datapath. Each of R independent rows merges two ascending-sorted N-element runs into one 2N-element sorted run through a registered bitonic merge network. Flow control is a valid/ready handshake, and the sort direction is selected per transaction. The block sits between the run-sort stage and the next merge level or the output buffer, so clock rate is set by one compare-exchange layer instead of the whole network.

---
 rtl/merge_pipe_row.sv | 162 ++++++++++++++++
 tb/tb_merge_pipe_row.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_pipe_row.sv
// ----------------------------------------------------------------------------
// merge_pipe_row
//
// Merges two ascending-sorted N-element runs into one sorted 2N-element run,
// independently for each of R rows, through a registered bitonic merge
// network. There is one compare-exchange layer per pipeline stage, so the
// pipeline has L = log2(2N) stages. The sort direction is chosen per
// transaction and travels down the pipe with its data.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   inba/desc valid
//   in_ready   block accepts when in_valid && in_ready
//   desc       0 = ascending output, 1 = descending; sampled with inba
//   inba       per row r: run a at [r*2N*W +: N*W], run b at the next N*W bits;
//              element k of a run is at W*k, element 0 smallest
//   out_valid  c/out_desc valid
//   out_ready  downstream accepts when out_valid && out_ready
//   c          per row r: 2N merged elements at [r*2N*W +: 2N*W], element 0
//              first in the selected order
//   out_desc   direction of the transaction currently on c
//   done_cnt   number of completed output transfers, wraps at 16 bits
// ----------------------------------------------------------------------------
module merge_pipe_row #(
    parameter int WIDTH = 2,
    parameter int N     = 8,
    parameter int R     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     desc,
    input  logic [2*N*R*WIDTH-1:0]   inba,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N*R*WIDTH-1:0]   c,
    output logic                     out_desc,
    output logic [15:0]              done_cnt
);

    localparam int ROW_W = 2 * N * WIDTH;
    localparam int BUS_W = R * ROW_W;
    localparam int L     = $clog2(2 * N);

    // Every stage moves together whenever the output slot is free or is
    // being drained this cycle; otherwise the whole pipe freezes.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Reversing run b turns a ++ rev(b) into a bitonic sequence, which the
    // half-cleaner cascade below sorts completely.
    logic [BUS_W-1:0] pre_data;

    always_comb begin
        pre_data = '0;
        for (int r = 0; r < R; r++) begin
            for (int k = 0; k < N; k++) begin
                pre_data[r*ROW_W + k*WIDTH +: WIDTH] =
                    inba[r*ROW_W + k*WIDTH +: WIDTH];
                pre_data[r*ROW_W + (N+k)*WIDTH +: WIDTH] =
                    inba[r*ROW_W + N*WIDTH + (N-1-k)*WIDTH +: WIDTH];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_stage
            // Compare distance halves at each stage: N, N/2, ..., 1.
            localparam int D = (2 * N) >> (gi + 1);

            logic [BUS_W-1:0] src_data;
            logic             src_valid;
            logic             src_desc;
            logic [BUS_W-1:0] data_d, data_q;
            logic             valid_d, valid_q;
            logic             desc_d, desc_q;

            if (gi == 0) begin : g_src
                assign src_data  = pre_data;
                assign src_valid = in_valid;
                assign src_desc  = desc;
            end else begin : g_src
                assign src_data  = g_stage[gi-1].data_q;
                assign src_valid = g_stage[gi-1].valid_q;
                assign src_desc  = g_stage[gi-1].desc_q;
            end

            always_comb begin
                logic [WIDTH-1:0] lo_v;
                logic [WIDTH-1:0] hi_v;
                int               i_idx;
                int               j_idx;
                lo_v    = '0;
                hi_v    = '0;
                i_idx   = 0;
                j_idx   = 0;
                data_d  = data_q;
                valid_d = valid_q;
                desc_d  = desc_q;
                if (adv) begin
                    data_d  = src_data;
                    valid_d = src_valid;
                    desc_d  = src_desc;
                    for (int r = 0; r < R; r++) begin
                        // Enumerate the N pairs (i, i+D) directly so no
                        // index ever leaves the row.
                        for (int p = 0; p < N; p++) begin
                            i_idx = (p / D) * 2 * D + (p % D);
                            j_idx = i_idx + D;
                            lo_v  = src_data[r*ROW_W + i_idx*WIDTH +: WIDTH];
                            hi_v  = src_data[r*ROW_W + j_idx*WIDTH +: WIDTH];
                            if (src_desc ? (lo_v < hi_v) : (lo_v > hi_v)) begin
                                data_d[r*ROW_W + i_idx*WIDTH +: WIDTH] = hi_v;
                                data_d[r*ROW_W + j_idx*WIDTH +: WIDTH] = lo_v;
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    desc_q  <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                    desc_q  <= desc_d;
                end
            end
        end
    endgenerate

    assign c         = g_stage[L-1].data_q;
    assign out_valid = g_stage[L-1].valid_q;
    assign out_desc  = g_stage[L-1].desc_q;

    logic [15:0] done_cnt_d, done_cnt_q;

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (out_valid && out_ready) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= 16'd0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_merge_pipe_row.sv
// ----------------------------------------------------------------------------
// tb_merge_pipe_row
//
// Scoreboard bench for merge_pipe_row. dut1 uses the default parameters,
// dut2 uses WIDTH=4, N=4, R=2. Expected results are computed by a plain
// sort of each row's 2N input elements when a transfer is accepted and are
// compared in order when the DUT hands a result downstream.
// ----------------------------------------------------------------------------
module tb_merge_pipe_row;

    typedef struct {
        logic [63:0] data;
        logic        dsc;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid1, in_ready1, desc1, out_valid1, out_ready1, out_desc1;
    logic [31:0] inba1, c1;
    logic [15:0] done_cnt1;

    logic        in_valid2, in_ready2, desc2, out_valid2, out_ready2, out_desc2;
    logic [63:0] inba2, c2;
    logic [15:0] done_cnt2;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_out1   = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   out_cyc_q[$];

    merge_pipe_row dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .desc      (desc1),
        .inba      (inba1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .c         (c1),
        .out_desc  (out_desc1),
        .done_cnt  (done_cnt1)
    );

    merge_pipe_row #(.WIDTH(4), .N(4), .R(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .desc      (desc2),
        .inba      (inba2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .c         (c2),
        .out_desc  (out_desc2),
        .done_cnt  (done_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: sort all 2n elements of each row, reverse for descending.
    function automatic logic [63:0] model(input logic [63:0] bus, input int w,
                                          input int n, input int rows, input logic dsc);
        int          v[16];
        int          t;
        int          m;
        int          idx;
        logic [63:0] msk;
        logic [63:0] res;
        m   = 2 * n;
        msk = (64'd1 << w) - 64'd1;
        res = '0;
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < m; j++) v[j] = int'((bus >> ((r*m + j) * w)) & msk);
            for (int i = 1; i < m; i++) begin
                for (int j = i; j > 0; j--) begin
                    if (v[j-1] > v[j]) begin
                        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                    end
                end
            end
            for (int j = 0; j < m; j++) begin
                idx = dsc ? (m - 1 - j) : j;
                res = res | (64'(v[idx]) << ((r*m + j) * w));
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] pack(input int vals[16], input int w);
        logic [63:0] res;
        res = '0;
        for (int j = 0; j < 16; j++)
            res = res | ((64'(vals[j]) & ((64'd1 << w) - 64'd1)) << (j * w));
        return res;
    endfunction

    // Two random ascending 8-element runs of 2-bit keys.
    function automatic logic [31:0] rand_bus1();
        int          vals[16];
        int          v;
        logic [63:0] tmp;
        for (int h = 0; h < 2; h++) begin
            v = int'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
                vals[h*8 + k] = v;
                v = v + int'($urandom_range(0, 1));
                if (v > 3) v = 3;
            end
        end
        tmp = pack(vals, 2);
        return tmp[31:0];
    endfunction

    // Scoreboards: push at acceptance, pop at output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_out", 64'(c1), 64'hx);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1_c", 64'(c1), e1.data);
                    check("dut1_out_desc", 64'(out_desc1), 64'(e1.dsc));
                end
                out_cyc_q.push_back(cyc);
                n_out1++;
                $display("dut1 out cyc=%0d c=%h desc=%0d", cyc, c1, out_desc1);
            end
            if (in_valid1 && in_ready1)
                q1.push_back('{model(64'(inba1), 2, 8, 1, desc1), desc1});
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    check("dut2_unexpected_out", c2, 64'hx);
                end else begin
                    e2 = q2.pop_front();
                    check("dut2_c", c2, e2.data);
                    check("dut2_out_desc", 64'(out_desc2), 64'(e2.dsc));
                end
                $display("dut2 out cyc=%0d c=%h desc=%0d", cyc, c2, out_desc2);
            end
            if (in_valid2 && in_ready2)
                q2.push_back('{model(inba2, 4, 4, 2, desc2), desc2});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send1(input logic [31:0] bus, input logic dsc, output int waited);
        in_valid1 = 1'b1;
        inba1     = bus;
        desc1     = dsc;
        waited    = 0;
        @(negedge clk);
        while (!in_ready1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready1) check("send1_timeout", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic send2(input logic [63:0] bus, input logic dsc, output int waited);
        in_valid2 = 1'b1;
        inba2     = bus;
        desc2     = dsc;
        waited    = 0;
        @(negedge clk);
        while (!in_ready2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready2) check("send2_timeout", 64'(in_ready2), 64'd1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q1.size() > 0 || q2.size() > 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 64'(q1.size() + q2.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Count negedges from the acceptance edge until out_valid shows.
    task automatic measure_latency(input string tag, input int dut_sel, input int expect_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dut_sel == 1 ? out_valid1 : out_valid2) && n < 20);
        check(tag, 64'(n), 64'(expect_lat));
    endtask

    int          va[16] = '{0,0,1,1,2,3,3,3, 0,1,1,2,2,2,3,3};
    int          vb[16] = '{1,5,9,13, 2,3,14,15, 15,15,15,15, 0,0,0,0};
    logic [63:0] tmp;
    logic [31:0] bus_a;
    logic [63:0] bus_b;
    logic [31:0] snap;
    logic [15:0] d0;
    int          w, wsum, ws, cnt;
    bit          rdone;

    initial begin
        rst_n      = 1'b0;
        in_valid1  = 1'b0; desc1 = 1'b0; inba1 = '0; out_ready1 = 1'b1;
        in_valid2  = 1'b0; desc2 = 1'b0; inba2 = '0; out_ready2 = 1'b1;
        tmp   = pack(va, 2);
        bus_a = tmp[31:0];
        bus_b = pack(vb, 4);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_in_ready", 64'(in_ready1), 64'd1);
        check("rst_c", 64'(c1), 64'd0);
        check("rst_out_desc", 64'(out_desc1), 64'd0);
        check("rst_done_cnt", 64'(done_cnt1), 64'd0);
        check("rst_out_valid2", 64'(out_valid2), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ascending merge, latency 4
        send1(bus_a, 1'b0, w);
        measure_latency("latency_dut1", 1, 4);
        drain();

        // Mixed directions back-to-back
        send1(bus_a, 1'b1, w);
        send1(bus_a, 1'b0, w);
        send1(bus_a, 1'b1, w);
        drain();

        // Four back-to-back with out_ready held high
        d0 = done_cnt1;
        out_cyc_q.delete();
        wsum = 0;
        for (int k = 0; k < 4; k++) begin
            send1(rand_bus1(), (k % 2) == 1, w);
            wsum += w;
        end
        check("b2b_in_ready_waits", 64'(wsum), 64'd0);
        drain();
        check("b2b_out_count", 64'(out_cyc_q.size()), 64'd4);
        for (int k = 1; k < out_cyc_q.size(); k++)
            check("b2b_consecutive", 64'(out_cyc_q[k] - out_cyc_q[k-1]), 64'd1);
        check("b2b_done_cnt_delta", 64'(done_cnt1 - d0), 64'd4);
        check("done_cnt_total", 64'(done_cnt1), 64'(16'(n_out1)));

        // Fill the pipe with out_ready low, hold the stall, then release
        out_ready1 = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) send1(rand_bus1(), (k % 2) == 0, w);
            end
            begin
                ws = 0;
                while (!out_valid1 && ws < 50) begin
                    @(negedge clk);
                    ws++;
                end
                check("stall_filled", 64'(out_valid1), 64'd1);
                snap = c1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready1), 64'd0);
                    check("stall_out_valid", 64'(out_valid1), 64'd1);
                    check("stall_c_stable", 64'(c1), 64'(snap));
                end
                @(posedge clk);
                #1;
                out_ready1 = 1'b1;
            end
        join
        drain();
        check("stall_done_cnt", 64'(done_cnt1), 64'(16'(n_out1)));

        // Random traffic under random backpressure
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 20; k++) send1(rand_bus1(), $urandom_range(0, 1) == 1, w);
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    out_ready1 = $urandom_range(0, 1) == 1;
                end
                out_ready1 = 1'b1;
            end
        join
        drain();

        // Second configuration: WIDTH=4, N=4, R=2, latency 3
        send2(bus_b, 1'b0, w);
        measure_latency("latency_dut2", 2, 3);
        drain();
        send2(bus_b, 1'b1, w);
        send2(bus_b, 1'b0, w);
        drain();

        // Reset with results in flight and one held on the output
        out_ready1 = 1'b0;
        send1(bus_a, 1'b0, w);
        send1(bus_a, 1'b1, w);
        ws = 0;
        while (!out_valid1 && ws < 50) begin
            @(negedge clk);
            ws++;
        end
        check("pre_rst_out_valid", 64'(out_valid1), 64'd1);
        check("pre_rst_done_cnt", 64'(done_cnt1), 64'(16'(n_out1)));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid1), 64'd0);
        check("midrst_c", 64'(c1), 64'd0);
        check("midrst_done_cnt", 64'(done_cnt1), 64'd0);
        check("midrst_in_ready", 64'(in_ready1), 64'd1);
        q1.delete();
        q2.delete();
        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        out_ready1 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid1) cnt++;
        end
        check("post_rst_idle_outputs", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        send1(bus_a, 1'b1, w);
        measure_latency("latency_after_rst", 1, 4);
        drain();
        check("post_rst_done_cnt", 64'(done_cnt1), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
